// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the binary-to-BCD converter and the display stage.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam int unsigned BCD_DEF_WIDTH  = 8;
    localparam int unsigned BCD_DEF_DIGITS = 3;

    // True when DIGITS decimal digits can represent every WIDTH-bit unsigned value.
    function automatic bit bcd_digits_ok(input int unsigned w, input int unsigned d);
        longint unsigned maxv;
        longint unsigned p;
        maxv = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        p    = 64'd1;
        for (int unsigned i = 0; (i < d) && (p <= maxv); i++) begin
            p = p * 64'd10;
        end
        return (p > maxv);
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Single-digit double-dabble correction: add 3 when the digit is 5 or more.
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Correct the digit so the following left shift carries cleanly into the next digit.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = BCD_DEF_WIDTH,
    parameter int unsigned DIGITS = BCD_DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    if (!bcd_digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small to hold every WIDTH-bit value");
    end

    bcd_state_t          state_q,   state_d;
    logic [WIDTH-1:0]    shreg_q,   shreg_d;
    logic [4*DIGITS-1:0] scratch_q, scratch_d;
    logic [CW-1:0]       cnt_q,     cnt_d;
    logic [4*DIGITS-1:0] bcd_q,     bcd_d;
    logic [4*DIGITS-1:0] corr;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (corr[4*g +: 4])
        );
    end

    // State and datapath registers; reset clears everything including any partial result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
        end
    end

    // Next-state and datapath update: load on accept, correct-then-shift while in SHIFT.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shreg_d} = {corr, shreg_q} << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = scratch_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (WIDTH=8, DIGITS=3).
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Decimal digits of v packed four bits per digit, ones first.
    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < 3; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit digits_valid(input logic [11:0] b);
        bit ok;
        ok = 1'b1;
        for (int d = 0; d < 3; d++) begin
            if (b[4*d +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one conversion from IDLE (called at a negedge) and check latency, busy, result and pulse width.
    task automatic convert(input logic [7:0] v, input string tag);
        int n;
        bit got;
        bit busy_ok;
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 8'($urandom);
        n = 0;
        got = 1'b0;
        busy_ok = 1'b1;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) got = 1'b1;
            else if (n < 8 && busy !== 1'b1) busy_ok = 1'b0;
        end
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_busy"}, {31'd0, busy_ok}, 1);
        chk({tag, "_bcd"}, {20'd0, bcd}, {20'd0, ref_bcd(int'(v))});
        chk({tag, "_digits"}, {31'd0, digits_valid(bcd)}, 1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_single_done"}, {31'd0, done}, 0);
        chk({tag, "_hold"}, {20'd0, bcd}, {20'd0, ref_bcd(int'(v))});
    endtask

    initial begin
        int n;
        int t_done[3];
        logic [11:0] b_done[3];
        int k;
        bit ok;

        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_bcd", {20'd0, bcd}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of a conversion of 200.
        bin = 8'd200;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_busy_before", {31'd0, busy}, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_done", {31'd0, done}, 0);
        chk("mid_rst_bcd", {20'd0, bcd}, 0);
        @(negedge clk);
        reset = 1'b0;
        ok = 1'b1;
        repeat (14) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) ok = 1'b0;
        end
        chk("mid_rst_stays_idle", {31'd0, ok}, 1);

        // Directed values and boundaries.
        convert(8'h0C, "v0c");
        convert(8'h55, "v55");
        convert(8'd0, "b0");
        convert(8'd255, "b255");
        convert(8'd9, "b9");
        convert(8'd10, "b10");
        convert(8'd99, "b99");
        convert(8'd100, "b100");

        // start pulsed during SHIFT and during DONE must be ignored.
        bin = 8'd42;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bin = 8'd77;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 3;
        while (!done && n < 40) begin
            @(negedge clk);
            if (!done) begin
                @(posedge clk);
                n++;
            end
        end
        chk("ign_latency", n, 8);
        chk("ign_bcd", {20'd0, bcd}, {20'd0, ref_bcd(42)});
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ok = 1'b1;
        k = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy !== 1'b0) ok = 1'b0;
            if (done === 1'b1) k++;
        end
        chk("ign_no_busy", {31'd0, ok}, 1);
        chk("ign_no_extra_done", k, 0);
        chk("ign_bcd_hold", {20'd0, bcd}, {20'd0, ref_bcd(42)});

        // start held high: back-to-back conversions of 1, 2, 3.
        bin = 8'd1;
        start = 1'b1;
        k = 0;
        n = 0;
        while (k < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (done) begin
                t_done[k] = cyc;
                b_done[k] = bcd;
                k++;
                bin = 8'(k + 1);
            end
        end
        start = 1'b0;
        chk("b2b_count", k, 3);
        if (k == 3) begin
            chk("b2b_gap1", t_done[1] - t_done[0], 10);
            chk("b2b_gap2", t_done[2] - t_done[1], 10);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("b2b_bcd%0d", i), {20'd0, b_done[i]}, {20'd0, ref_bcd(i + 1)});
            end
        end
        repeat (12) @(negedge clk);

        // Exhaustive sweep followed by random values.
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), $sformatf("sweep%0d", v));
        end
        for (int i = 0; i < 32; i++) begin
            convert(8'($urandom_range(255, 0)), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the display-conversion stage. It takes an unsigned binary value and produces packed BCD digits, which the display stage maps to segment patterns one digit at a time. A start/done handshake lets a controller or counter launch a conversion and latch the result.

## Interface
Parameters:
- WIDTH, 8, bit width of the unsigned binary input.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH − 1. Violation is an elaboration-time error.

Ports:
- clk  input  1  the single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  WIDTH  unsigned value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse: a new result has been written to bcd.
- bcd  output  4*DIGITS  registered result. Digit 0 (ones) is in bits [3:0]; digit d is in [4d+3:4d].

## Operation
- Registers:
  - state: IDLE, SHIFT or DONE.
  - shift register of WIDTH bits.
  - scratch accumulator of 4*DIGITS bits.
  - iteration counter, wide enough for WIDTH.
  - output register bcd.
- IDLE:
  - If start = 1, load bin into the shift register, clear the scratch accumulator, set counter = WIDTH, and go to SHIFT.
  - Otherwise hold.
- SHIFT, once per cycle:
  1. Each scratch digit ≥ 5 gets +3; digits are corrected independently with no inter-digit carry.
  2. Shift {scratch, shift register} left by one.
  3. Decrement the counter.
  - When the counter goes 1→0 on this edge, write the post-shift scratch value into bcd and go to DONE.
- DONE: lasts one cycle, then go to IDLE unconditionally. start is ignored in this state.
- Outputs:
  - busy = (state == SHIFT).
  - done = (state == DONE).
  - bcd changes only on the DONE-entry edge and holds between conversions.
- start while busy or in DONE is ignored; there is no queueing. bin may change freely after the accepting edge.
- Reset, asynchronous and at any time including mid-conversion:
  - state → IDLE, busy = 0, done = 0, bcd = 0, scratch, shift register and counter cleared.
  - A partial result is never written to bcd.
- Width rules: scratch digits never exceed 9 after correction plus shift, given a valid DIGITS. No overflow handling is required.

## Timing
- Start accepted at rising edge k (state IDLE, start = 1).
- busy = 1 from after edge k until after edge k+WIDTH.
- bcd updated and done = 1 in the cycle after edge k+WIDTH. Latency is WIDTH clocks from accept to result.
- Earliest next accept is edge k+WIDTH+2, so maximum throughput is one conversion per WIDTH+2 cycles.
- start held high continuously gives back-to-back conversions at that rate.
- No combinational path from any input to any output. All outputs come straight from registers or are decoded from state.

## Structure
- Shared header, included by this block and the display stage:
  - state encodings: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - default WIDTH and DIGITS constants.
- Sub-module bcd_add3: combinational, 4-bit in and 4-bit out; returns in+3 when in ≥ 5, else in. Instantiated DIGITS times with a generate loop.
- Top module holds the FSM, counter, datapath registers and the output register.

## Test plan
- Reset asserted mid-SHIFT at cycle 3 of a conversion of 8'd200: busy, done and bcd go to 0 immediately. After release, with no start, the block stays IDLE and bcd remains 12'h000.
- Accept 8'h0C, then 8'h55: after 8 clocks each, done pulses once, with bcd = 12'h012, then 12'h085.
- Boundaries:
  - 8'd0 → 12'h000.
  - 8'd255 → 12'h255.
  - 8'd9 → 12'h009.
  - 8'd10 → 12'h010.
  - 8'd99 → 12'h099.
  - 8'd100 → 12'h100.
- Start pulsed again during SHIFT and during DONE with bin = 8'd77: ignored. The result is still the first operand, there is exactly one done pulse, and busy is never extended.
- start held high continuously over bins 1, 2, 3: done pulses exactly 10 cycles apart with bcd = 12'h001, 12'h002, 12'h003.
- Exhaustive sweep of 0–255 against a reference model of the arithmetic: every bcd digit ≤ 9, the result matches, and latency is exactly 8 clocks in every case.
